// File: rtl/prach_pkg.sv
// Shared types and sizing for the PRACH channel-pairing stages.
package prach_pkg;

  localparam int NumChannel     = 32;
  localparam int NumChannelUsed = 24;

  typedef logic signed [15:0] sample_t;
  typedef logic [7:0]         chn_t;

  typedef enum logic {
    PH0 = 1'b0,
    PH1 = 1'b1
  } phase_t;

endpackage

// File: rtl/prach_delay.sv
// Fixed-depth resettable delay line for control/side-band alignment.
module prach_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/prach_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
module prach_sdp_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/prach_hb2_pair.sv
// HB2 front end: buffers phase-0 TDM samples and emits phase-0/phase-1 pairs
// for the used channels, with TDM sequence checking.
module prach_hb2_pair
  import prach_pkg::*;
#(
  parameter int NUM_CHANNEL      = NumChannel,
  parameter int NUM_CHANNEL_USED = NumChannelUsed,
  parameter int DW               = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din_dq,
  input  logic          din_dv,
  input  logic [7:0]    din_chn,
  input  logic          sync_in,
  output logic [DW-1:0] dout_dp1,
  output logic [DW-1:0] dout_dp2,
  output logic          dout_dv,
  output logic [7:0]    dout_chn,
  output logic          sync_out,
  output logic          err_seq
);

  localparam int   AW      = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1;
  localparam chn_t ChnNum  = chn_t'(NUM_CHANNEL);
  localparam chn_t ChnLast = chn_t'(NUM_CHANNEL - 1);
  localparam chn_t ChnUsed = chn_t'(NUM_CHANNEL_USED);
  localparam int   SW      = 2 + 8 + DW;

  phase_t        phase, phase_nxt;
  chn_t          exp_chn, exp_chn_nxt;
  logic          sync_pending, sync_pending_nxt;
  logic          err_nxt;
  logic          wr_en, rd_en, pair_sync;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] ram_q;

  always_comb begin
    phase_nxt        = phase;
    exp_chn_nxt      = exp_chn;
    sync_pending_nxt = sync_pending;
    err_nxt          = err_seq;
    wr_en            = 1'b0;
    rd_en            = 1'b0;
    pair_sync        = 1'b0;
    wr_addr          = din_chn[AW-1:0];
    if (din_dv) begin
      if (sync_in) begin
        // A sync beat is phase-0 channel 0 whatever din_chn carries.
        phase_nxt        = PH0;
        exp_chn_nxt      = 8'd1;
        sync_pending_nxt = 1'b1;
        err_nxt          = 1'b0;
        wr_en            = 1'b1;
        wr_addr          = '0;
      end else if (din_chn != exp_chn || din_chn >= ChnNum) begin
        err_nxt = 1'b1;
      end else begin
        exp_chn_nxt = (din_chn == ChnLast) ? '0 : chn_t'(din_chn + 8'd1);
        if (din_chn == ChnLast) phase_nxt = (phase == PH0) ? PH1 : PH0;
        if (phase == PH0) begin
          wr_en = 1'b1;
        end else if (din_chn < ChnUsed) begin
          rd_en = 1'b1;
          if (din_chn == '0 && sync_pending) begin
            pair_sync        = 1'b1;
            sync_pending_nxt = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase        <= PH0;
      exp_chn      <= '0;
      sync_pending <= 1'b0;
      err_seq      <= 1'b0;
    end else begin
      phase        <= phase_nxt;
      exp_chn      <= exp_chn_nxt;
      sync_pending <= sync_pending_nxt;
      err_seq      <= err_nxt;
    end
  end

  prach_sdp_ram #(
    .DEPTH (NUM_CHANNEL),
    .WIDTH (DW),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (din_dq),
    .rd_en   (rd_en),
    .rd_addr (din_chn[AW-1:0]),
    .rd_data (ram_q)
  );

  logic          s1_sync, s1_dv;
  logic [7:0]    s1_chn;
  logic [DW-1:0] s1_dq;

  // One stage matches the RAM read latency; the output register adds the second.
  prach_delay #(
    .WIDTH (SW),
    .DEPTH (1)
  ) u_align (
    .clk (clk),
    .rst (rst),
    .d   ({pair_sync, rd_en, din_chn, din_dq}),
    .q   ({s1_sync, s1_dv, s1_chn, s1_dq})
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_dv  <= 1'b0;
      sync_out <= 1'b0;
      dout_dp1 <= '0;
      dout_dp2 <= '0;
      dout_chn <= '0;
    end else begin
      dout_dv  <= s1_dv;
      sync_out <= s1_dv & s1_sync;
      if (s1_dv) begin
        dout_dp1 <= ram_q;
        dout_dp2 <= s1_dq;
        dout_chn <= s1_chn;
      end
    end
  end

endmodule

// File: doc/prach_hb2_pair.md
Name: prach_hb2_pair

Overview:
- Upstream stage of the HB2 decimate-by-2 channel filter.
- Takes the TDM sample stream from HB1 (one 16-bit sample per beat, channels round-robin), buffers the phase-0 sample of every channel, and emits phase-0/phase-1 pairs on the phase-1 frame as din_dp1/din_dp2 for the HB2 channel filter.
- Only used channels are forwarded. The output dv rate is half the input dv rate, times NumChannelUsed/NumChannel.
- Also checks TDM sequencing and flags slips.

Parameters:
NUM_CHANNEL, 32, TDM slots per frame (channel index 0..NUM_CHANNEL-1)
NUM_CHANNEL_USED, 24, channels forwarded; slots >= this are consumed but never emitted
DW, 16, sample width (signed, passed bit-exact)

Ports:
clk        in   1   clock
rst        in   1   synchronous reset, active-high
din_dq     in   DW  input sample
din_dv     in   1   input sample valid
din_chn    in   8   input channel index
sync_in    in   1   frame marker; valid only with din_dv; marks chn 0 of phase 0
dout_dp1   out  DW  phase-0 (earlier) sample of pair
dout_dp2   out  DW  phase-1 (later) sample of pair
dout_dv    out  1   pair valid
dout_chn   out  8   channel of pair
sync_out   out  1   first pair (chn 0) after a sync_in
err_seq    out  1   sticky sequencing error

Behaviour:
- Single clock domain. All state is reset synchronously when rst=1.
- Reset values:
  - dout_dv=0, sync_out=0, err_seq=0, dout_dp1=0, dout_dp2=0, dout_chn=0.
  - Internal phase=0, expected channel exp_chn=0, sync_pending=0.
  - RAM contents are not reset.
- Channel/phase tracking, evaluated on each din_dv beat:
  - If sync_in=1, the beat is treated as phase 0, channel 0. After it: phase=0, exp_chn=1, sync_pending=1, err_seq cleared.
  - Otherwise, if din_chn != exp_chn, or din_chn >= NUM_CHANNEL:
    - set err_seq;
    - drop the beat (no RAM write, no output);
    - leave phase and exp_chn unchanged.
    - err_seq stays set until the next sync_in or rst.
  - Otherwise the beat is accepted. exp_chn increments. On wrap from NUM_CHANNEL-1 to 0, phase toggles.
- Data path:
  - Phase-0 accepted beat: write din_dq to RAM[din_chn] (NUM_CHANNEL x DW, 1-cycle registered read). No output.
  - Phase-1 accepted beat with din_chn < NUM_CHANNEL_USED: read RAM[din_chn] and pipeline din_dq alongside. After exactly 2 clk: dout_dv=1, dout_dp1=RAM value, dout_dp2=din_dq, dout_chn=din_chn.
  - Phase-1 beat with chn >= NUM_CHANNEL_USED: no output.
- sync_out:
  - Asserted with the first emitted chn-0 pair while sync_pending=1. sync_pending clears on that beat.
  - A sync_in arriving while sync_pending=1 simply restarts tracking.
- Non-dv cycles: no state change. dout_dv=0 except for pipeline drain.
- Output fields:
  - Hold their last value when dout_dv=0 (not zeroed).
  - Are pure pipeline registers: a valid pair is never lost once accepted.
- Before the first sync_in after reset, beats are processed as if a sync had occurred at reset.
  - The first frame is treated as phase 0 starting at chn 0; no sync_out is produced.
- rst asserted mid-frame:
  - the pipeline is flushed (an in-flight pair is discarded, dout_dv=0 next cycle);
  - tracking restarts at phase 0, chn 0.
- Throughput: one input beat per clk, no backpressure. Latency is fixed at 2 clk from the phase-1 input beat to the output.

Decomposition:
- Shared package prach_pkg holds:
  - NumChannel=32, NumChannelUsed=24;
  - the sample typedef (logic signed [15:0]);
  - the chn_t typedef (logic [7:0]).
- One sub-module, prach_sdp_ram:
  - simple dual-port RAM, parameterised depth and width;
  - registered read, 1-cycle latency, no reset;
  - reused by later pairing stages.
- Output pipeline alignment uses the existing delay module for {sync, dv, chn}.

Test Plan:
- Reset, then sync_in with chn 0..31 continuous; phase 0 value = chn*2, phase 1 value = chn*2+1. Required: 24 outputs, dp1=chn*2, dp2=chn*2+1, chn 0..23, each 2 clk after its phase-1 input. sync_out only on chn 0. err_seq=0.
- Same stimulus with dv toggled 1-0-1 randomly (gaps up to 5 clk). Required: identical output sequence. No dv for chn 24..31. No output during phase 0.
- Negative values: phase-0 value -32768, phase-1 value 32767 on chn 5. Required: dp1=16'h8000, dp2=16'h7FFF, unmodified.
- Phase-1 frame skips chn 10 (9 then 11). Required: err_seq=1 next clk, chn 11 beat dropped, subsequent beats dropped until the next sync_in. After the re-sync, normal pairs resume and err_seq=0.
- sync_in mid-frame at phase-1 chn 17. Required: no pair for chn 17. That beat is stored as phase-0 chn 0. The next frame's pairs start at chn 0 with sync_out=1.
- rst pulse on the clk after the phase-1 chn 3 input. Required: no dout_dv for chn 3. All outputs return to 0. The next frame after reset is treated as phase 0.
